// File: rtl/chk_reg_i.sv
// -----------------------------------------------------------------------------
// chk_reg_i
//
// Receiving-end checker for the initialised / inverting register stream.
// It watches the 8-bit bus `dato` and confirms three properties:
//   * the stream arms on the start pattern INI,
//   * every change is the bitwise inversion of the last accepted value,
//   * changes keep coming at least once every TMAX = 2^(N0+1) cycles.
//
// State encoding on `estado`: 00 BUSCA (searching), 01 ENGANCHADO (locked),
// 10 FALLO (one-cycle failure pulse). Encoding 11 falls back to BUSCA.
//
// Parameters
//   INI     start pattern that arms the checker
//   N0      prescaler exponent; nominal change period is 2^N0 clk cycles
//
// Ports
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   dato    monitored stream, synchronous to clk
//   ok      high only while locked
//   err     sticky error flag, cleared only by reset
//   n_err   error count, saturates at 255
//   n_trans count of accepted inversions, wraps 65535 -> 0
//   estado  current state
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module chk_reg_i #(
  parameter logic [7:0] INI = 8'b00001111,
  parameter int         N0  = 19
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  dato,
  output logic        ok,
  output logic        err,
  output logic [7:0]  n_err,
  output logic [15:0] n_trans,
  output logic [1:0]  estado
);

  // Stall timer spans 0 .. TMAX-1 with TMAX = 2^(N0+1).
  localparam int TW = N0 + 2;
  // TMAX-1 is (N0+1) ones, i.e. all-ones of width TW shifted right by one.
  localparam logic [TW-1:0] TLAST = {TW{1'b1}} >> 1;

  typedef enum logic [1:0] {
    BUSCA      = 2'b00,
    ENGANCHADO = 2'b01,
    FALLO      = 2'b10
  } st_e;

  st_e             estado_q;
  logic [7:0]      d_q;
  logic [7:0]      prev_q;
  logic [7:0]      ref_q;
  logic [TW-1:0]   tmr_q;
  logic            ok_q;
  logic            err_q;
  logic [7:0]      n_err_q;
  logic [15:0]     n_trans_q;

  // A change is judged on the registered copy against its one-cycle history,
  // so the whole decision path is fully synchronous to clk.
  logic cambio;
  assign cambio = (d_q != prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q       <= '0;
      prev_q    <= '0;
      ref_q     <= '0;
      tmr_q     <= '0;
      estado_q  <= BUSCA;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      n_err_q   <= '0;
      n_trans_q <= '0;
    end else begin
      d_q    <= dato;
      prev_q <= d_q;

      case (estado_q)
        BUSCA: begin
          tmr_q <= '0;
          if (d_q == INI) begin
            ref_q    <= d_q;
            estado_q <= ENGANCHADO;
            ok_q     <= 1'b1;
          end
        end

        ENGANCHADO: begin
          // A change is always judged first: a valid inversion that lands on
          // the last timer count is accepted rather than flagged as a stall.
          if (cambio) begin
            if (d_q == ~ref_q) begin
              ref_q     <= d_q;
              tmr_q     <= '0;
              n_trans_q <= n_trans_q + 16'd1;
            end else begin
              estado_q <= FALLO;
              ok_q     <= 1'b0;
              err_q    <= 1'b1;
              tmr_q    <= '0;
              if (n_err_q != 8'hFF) n_err_q <= n_err_q + 8'd1;
            end
          end else if (tmr_q == TLAST) begin
            estado_q <= FALLO;
            ok_q     <= 1'b0;
            err_q    <= 1'b1;
            tmr_q    <= '0;
            if (n_err_q != 8'hFF) n_err_q <= n_err_q + 8'd1;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end

        FALLO: begin
          // One-cycle pulse; re-arming happens from BUSCA.
          estado_q <= BUSCA;
          ok_q     <= 1'b0;
          tmr_q    <= '0;
        end

        default: begin
          estado_q <= BUSCA;
          ok_q     <= 1'b0;
          tmr_q    <= '0;
        end
      endcase
    end
  end

  assign ok      = ok_q;
  assign err     = err_q;
  assign n_err   = n_err_q;
  assign n_trans = n_trans_q;
  assign estado  = estado_q;

endmodule
